otp_main: RTL and testbench
===========================

OTP_MAIN -- requirements
Module: otp_main

Interface
REQ-001 Parameter NUM_BYTES, 16, number of OTP bytes mirrored into the register file (2..16).
REQ-002 Parameter RD_STB, 2, read strobe high time in sys_clk cycles (>=1).
REQ-003 Parameter PG_STB, 4, program strobe high time in sys_clk cycles (>=1).
REQ-004 Parameter VQ_SETTLE, 2, cycles between o_otp_vddqsw edges and first/after last program activity (>=1).
REQ-005 sys_clk  in  1  single clock; all logic on rising edge.
REQ-006 rst_n  in  1  asynchronous reset, active-high despite its name (1 = reset).
REQ-007 i_i2c_busy  in  1  I2C transaction in progress; new operations are not started while 1.
REQ-008 i_run_test_mode  in  1  1 enables programming; read is always permitted.
REQ-009 i_otp_read_n  in  1  active-low read request; falling edge requests a full read.
REQ-010 i_otp_prog  in  1  rising edge requests a full program.
REQ-011 o_otp_vddqsw  out  1  OTP program supply switch enable.
REQ-012 o_otp_csb  out  1  OTP chip select, active-low.
REQ-013 o_otp_strobe  out  1  OTP read/program strobe.
REQ-014 o_otp_load  out  1  OTP read mode; also the register-file write qualifier.
REQ-015 i_otp_q  in  8  OTP read data.
REQ-016 o_otp_addr  out  7  OTP address: [6:3] byte index, [2:0] bit index.
REQ-017 o_otp_pgenb  out  1  OTP program enable, active-low.
REQ-018 o_xbus_din  out  8  data written to the register file.
REQ-019 o_xbus_addr  out  7  register-file address; 7'h7F = no access.
REQ-020 i_xbus_dout  in  8  register-file read data, combinational from o_xbus_addr.

Function
REQ-021 Reset values: vddqsw 0, csb 1, strobe 0, load 0, addr 0, pgenb 1, xbus_din 8'h00, xbus_addr 7'h7F, pending flags cleared, state IDLE.
REQ-022 States: IDLE, RD_SETUP, RD_STB, RD_WR, PG_VQ_ON, PG_FETCH, PG_BIT, PG_STB, PG_GAP, PG_VQ_OFF.
REQ-023 Edge detectors on i_otp_read_n (fall) and i_otp_prog (rise) set sticky read_pend / prog_pend flags; a prog edge while i_run_test_mode=0 is discarded.
REQ-024 A power-on read_pend is set on reset release so the OTP is loaded once automatically.
REQ-025 IDLE leaves only when i_i2c_busy=0; read_pend has priority over prog_pend; the chosen flag clears on leaving IDLE, the other stays pending.
REQ-026 Edges occurring during an operation set their flag and are served after return to IDLE.
REQ-027 Read: csb=0, load=1, pgenb=1, vddqsw=0 throughout; for byte i=0..NUM_BYTES-1: RD_SETUP 1 cycle with addr={i,3'b000}; RD_STB strobe=1 for RD_STB cycles, i_otp_q captured on the last; RD_WR 1 cycle strobe=0, xbus_addr=i, xbus_din=captured byte.
REQ-028 The register file writes xbus_din at xbus_addr on every cycle with load=1 and xbus_addr!=7'h7F; xbus_addr SHALL be 7'h7F in every other read cycle.
REQ-029 After the last byte, return to IDLE: csb=1, load=0, addr=0; xbus_din holds the last value.
REQ-030 Program: PG_VQ_ON sets vddqsw=1, csb=0, pgenb=0, load=0 for VQ_SETTLE cycles.
REQ-031 PG_FETCH per byte i: xbus_addr=i for 1 cycle, i_xbus_dout latched at end of cycle, then xbus_addr=7'h7F.
REQ-032 PG_BIT scans bits 0..7: bit=1 -> addr={i,b}, PG_STB strobe=1 for PG_STB cycles, then PG_GAP strobe=0 for 1 cycle; bit=0 -> 1 cycle, no strobe.
REQ-033 After byte NUM_BYTES-1, PG_VQ_OFF: pgenb=1, csb=1, strobe=0 for VQ_SETTLE cycles with vddqsw=1, then vddqsw=0 and IDLE.
REQ-034 i_run_test_mode falling to 0 during program aborts at the next cycle boundary via PG_VQ_OFF (strobe dropped immediately); i_i2c_busy is ignored once an operation started.
REQ-035 o_otp_strobe is never 1 while csb=1, and pgenb=0 only while vddqsw=1.
REQ-036 All outputs are registered.

Reset
REQ-037 Asserting rst_n at any time, including mid-strobe, forces REQ-021 values asynchronously; operations are aborted, not resumed, and the auto-load re-runs on release.

Verification
REQ-038 Reset released, i_i2c_busy=1 until 25 ns, i_otp_q=8'hA5 -> auto-load starts only after busy low; 16 writes of 8'hA5 to xbus_addr 0..15.
REQ-039 i_run_test_mode=1, i_otp_prog rises, i_xbus_dout=8'h66 -> per byte 4 strobes of 4 cycles at addr bits 1,2,5,6; 64 strobes total; pgenb=0 only inside vddqsw=1.
REQ-040 i_run_test_mode=0, i_otp_prog rises -> no strobe, vddqsw stays 0.
REQ-041 i_otp_read_n falls and i_otp_prog rises same cycle -> full read first, then full program.
REQ-042 rst_n=1 during a program strobe -> strobe=0, vddqsw=0, pgenb=1, csb=1 immediately.
REQ-043 Random i_otp_q changing every 12 ns during read -> each xbus write equals i_otp_q sampled on the last strobe cycle of that byte.

Source files
------------

// File: rtl/otp_main.sv
// otp_main: mirrors OTP fuse bytes into the register file on load and
// burns register-file bytes into the OTP on program.
`timescale 1ns/1ps
module otp_main #(
    parameter int NUM_BYTES = 16,
    parameter int RD_STB    = 2,
    parameter int PG_STB    = 4,
    parameter int VQ_SETTLE = 2
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       i_i2c_busy,
    input  logic       i_run_test_mode,
    input  logic       i_otp_read_n,
    input  logic       i_otp_prog,
    output logic       o_otp_vddqsw,
    output logic       o_otp_csb,
    output logic       o_otp_strobe,
    output logic       o_otp_load,
    input  logic [7:0] i_otp_q,
    output logic [6:0] o_otp_addr,
    output logic       o_otp_pgenb,
    output logic [7:0] o_xbus_din,
    output logic [6:0] o_xbus_addr,
    input  logic [7:0] i_xbus_dout
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_SETUP,
        S_RD_STB,
        S_RD_WR,
        S_PG_VQ_ON,
        S_PG_FETCH,
        S_PG_BIT,
        S_PG_STB,
        S_PG_GAP,
        S_PG_VQ_OFF
    } state_t;

    localparam logic [3:0]  LAST_BYTE = 4'(NUM_BYTES - 1);
    localparam logic [15:0] RD_LAST   = 16'(RD_STB - 1);
    localparam logic [15:0] PG_LAST   = 16'(PG_STB - 1);
    localparam logic [15:0] VQ_LAST   = 16'(VQ_SETTLE - 1);
    localparam logic [6:0]  NO_ACC    = 7'h7F;

    state_t      state, state_n, adv_state;
    logic [3:0]  byte_q, byte_n, adv_byte;
    logic [2:0]  bit_q, bit_n, adv_bit;
    logic [15:0] cnt_q, cnt_n;
    logic [7:0]  data_q, data_n;
    logic        por_q, read_n_q, prog_q;
    logic        read_pend, prog_pend, read_pend_n, prog_pend_n;
    logic        read_fall, prog_rise, pg_active;

    logic        vq_n, csb_n, stb_n, load_n, pgenb_n;
    logic [6:0]  addr_n, xaddr_n;
    logic [7:0]  din_n;

    // Edges are ignored in the first cycle after reset while the
    // detector registers pick up the real pin levels.
    assign read_fall = !por_q && read_n_q && !i_otp_read_n;
    assign prog_rise = !por_q && !prog_q && i_otp_prog && i_run_test_mode;

    assign pg_active = (state == S_PG_VQ_ON) || (state == S_PG_FETCH) ||
                       (state == S_PG_BIT) || (state == S_PG_STB) ||
                       (state == S_PG_GAP);

    always_comb begin
        adv_state = S_PG_BIT;
        adv_byte  = byte_q;
        adv_bit   = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
            adv_bit = 3'd0;
            if (byte_q == LAST_BYTE) begin
                adv_state = S_PG_VQ_OFF;
            end else begin
                adv_state = S_PG_FETCH;
                adv_byte  = byte_q + 4'd1;
            end
        end
    end

    always_comb begin
        state_n     = state;
        byte_n      = byte_q;
        bit_n       = bit_q;
        cnt_n       = cnt_q;
        data_n      = data_q;
        din_n       = o_xbus_din;
        read_pend_n = read_pend || read_fall || por_q;
        prog_pend_n = prog_pend || prog_rise;
        if (pg_active && !i_run_test_mode) begin
            state_n = S_PG_VQ_OFF;
            cnt_n   = '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (!i_run_test_mode) prog_pend_n = 1'b0;
                    if (!i_i2c_busy) begin
                        if (read_pend) begin
                            state_n     = S_RD_SETUP;
                            byte_n      = '0;
                            read_pend_n = read_fall;
                        end else if (prog_pend && i_run_test_mode) begin
                            state_n     = S_PG_VQ_ON;
                            byte_n      = '0;
                            cnt_n       = '0;
                            prog_pend_n = prog_rise;
                        end
                    end
                end
                S_RD_SETUP: begin
                    state_n = S_RD_STB;
                    cnt_n   = '0;
                end
                S_RD_STB: begin
                    if (cnt_q == RD_LAST) begin
                        state_n = S_RD_WR;
                        din_n   = i_otp_q;
                    end else begin
                        cnt_n = cnt_q + 16'd1;
                    end
                end
                S_RD_WR: begin
                    if (byte_q == LAST_BYTE) begin
                        state_n = S_IDLE;
                    end else begin
                        state_n = S_RD_SETUP;
                        byte_n  = byte_q + 4'd1;
                    end
                end
                S_PG_VQ_ON: begin
                    if (cnt_q == VQ_LAST) state_n = S_PG_FETCH;
                    else cnt_n = cnt_q + 16'd1;
                end
                S_PG_FETCH: begin
                    state_n = S_PG_BIT;
                    bit_n   = '0;
                    data_n  = i_xbus_dout;
                end
                S_PG_BIT: begin
                    if (data_q[bit_q]) begin
                        state_n = S_PG_STB;
                        cnt_n   = '0;
                    end else begin
                        state_n = adv_state;
                        byte_n  = adv_byte;
                        bit_n   = adv_bit;
                        cnt_n   = '0;
                    end
                end
                S_PG_STB: begin
                    if (cnt_q == PG_LAST) state_n = S_PG_GAP;
                    else cnt_n = cnt_q + 16'd1;
                end
                S_PG_GAP: begin
                    state_n = adv_state;
                    byte_n  = adv_byte;
                    bit_n   = adv_bit;
                    cnt_n   = '0;
                end
                S_PG_VQ_OFF: begin
                    if (cnt_q == VQ_LAST) state_n = S_IDLE;
                    else cnt_n = cnt_q + 16'd1;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they register in step
    // with the state they belong to.
    always_comb begin
        vq_n    = 1'b0;
        csb_n   = 1'b1;
        stb_n   = 1'b0;
        load_n  = 1'b0;
        pgenb_n = 1'b1;
        addr_n  = '0;
        xaddr_n = NO_ACC;
        unique case (state_n)
            S_RD_SETUP, S_RD_STB, S_RD_WR: begin
                csb_n  = 1'b0;
                load_n = 1'b1;
                addr_n = {byte_n, 3'b000};
                stb_n  = (state_n == S_RD_STB);
                if (state_n == S_RD_WR) xaddr_n = {3'b000, byte_n};
            end
            S_PG_VQ_ON: begin
                vq_n    = 1'b1;
                csb_n   = 1'b0;
                pgenb_n = 1'b0;
            end
            S_PG_FETCH: begin
                vq_n    = 1'b1;
                csb_n   = 1'b0;
                pgenb_n = 1'b0;
                addr_n  = {byte_n, 3'b000};
                xaddr_n = {3'b000, byte_n};
            end
            S_PG_BIT, S_PG_STB, S_PG_GAP: begin
                vq_n    = 1'b1;
                csb_n   = 1'b0;
                pgenb_n = 1'b0;
                addr_n  = {byte_n, bit_n};
                stb_n   = (state_n == S_PG_STB);
            end
            S_PG_VQ_OFF: vq_n = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst_n) begin
        if (rst_n) begin
            state        <= S_IDLE;
            byte_q       <= '0;
            bit_q        <= '0;
            cnt_q        <= '0;
            data_q       <= '0;
            por_q        <= 1'b1;
            read_n_q     <= 1'b1;
            prog_q       <= 1'b0;
            read_pend    <= 1'b0;
            prog_pend    <= 1'b0;
            o_otp_vddqsw <= 1'b0;
            o_otp_csb    <= 1'b1;
            o_otp_strobe <= 1'b0;
            o_otp_load   <= 1'b0;
            o_otp_addr   <= '0;
            o_otp_pgenb  <= 1'b1;
            o_xbus_din   <= 8'h00;
            o_xbus_addr  <= NO_ACC;
        end else begin
            state        <= state_n;
            byte_q       <= byte_n;
            bit_q        <= bit_n;
            cnt_q        <= cnt_n;
            data_q       <= data_n;
            por_q        <= 1'b0;
            read_n_q     <= i_otp_read_n;
            prog_q       <= i_otp_prog;
            read_pend    <= read_pend_n;
            prog_pend    <= prog_pend_n;
            o_otp_vddqsw <= vq_n;
            o_otp_csb    <= csb_n;
            o_otp_strobe <= stb_n;
            o_otp_load   <= load_n;
            o_otp_addr   <= addr_n;
            o_otp_pgenb  <= pgenb_n;
            o_xbus_din   <= din_n;
            o_xbus_addr  <= xaddr_n;
        end
    end

endmodule

// File: tb/tb_otp_main.sv
// tb_otp_main: directed scenarios for the OTP load/program controller
// with hand-derived expectations.
`timescale 1ns/1ps
module tb_otp_main;

    logic       sys_clk, rst_n, i_i2c_busy, i_run_test_mode;
    logic       i_otp_read_n, i_otp_prog;
    logic       o_otp_vddqsw, o_otp_csb, o_otp_strobe, o_otp_load, o_otp_pgenb;
    logic [7:0] i_otp_q, o_xbus_din, i_xbus_dout;
    logic [6:0] o_otp_addr, o_xbus_addr;

    int checks = 0;
    int failures = 0;

    otp_main dut (
        .sys_clk        (sys_clk),
        .rst_n          (rst_n),
        .i_i2c_busy     (i_i2c_busy),
        .i_run_test_mode(i_run_test_mode),
        .i_otp_read_n   (i_otp_read_n),
        .i_otp_prog     (i_otp_prog),
        .o_otp_vddqsw   (o_otp_vddqsw),
        .o_otp_csb      (o_otp_csb),
        .o_otp_strobe   (o_otp_strobe),
        .o_otp_load     (o_otp_load),
        .i_otp_q        (i_otp_q),
        .o_otp_addr     (o_otp_addr),
        .o_otp_pgenb    (o_otp_pgenb),
        .o_xbus_din     (o_xbus_din),
        .o_xbus_addr    (o_xbus_addr),
        .i_xbus_dout    (i_xbus_dout)
    );

    // Rising edges at 10, 20, 30 ... ns.
    initial begin
        sys_clk = 1'b1;
        forever #5 sys_clk = ~sys_clk;
    end

    int         w_n = 0;
    logic [6:0] w_addr[512];
    logic [7:0] w_data[512];
    longint     w_time[512];
    int         s_n = 0;
    int         s_run = 0;
    logic [6:0] s_addr[512];
    int         s_w[512];
    bit         s_pg[512];
    int         v_csb = 0, v_pg = 0, vq_rise = 0, csb_low = 0;
    logic       vq_d = 1'b0, stb_d = 1'b0;
    longint     first_csb_t = -1;
    logic [7:0] tbl[128];

    initial begin
        forever begin
            @(negedge sys_clk);
            if (o_otp_load && o_xbus_addr != 7'h7F) begin
                if (w_n < 512) begin
                    w_addr[w_n] = o_xbus_addr;
                    w_data[w_n] = o_xbus_din;
                    w_time[w_n] = $time;
                end
                w_n++;
            end
            if (o_otp_strobe) begin
                if (!stb_d && s_n < 512) begin
                    s_addr[s_n] = o_otp_addr;
                    s_pg[s_n]   = !o_otp_load;
                end
                s_run++;
            end else if (stb_d) begin
                if (s_n < 512) s_w[s_n] = s_run;
                s_n++;
                s_run = 0;
            end
            if (o_otp_strobe && o_otp_csb) v_csb++;
            if (!o_otp_pgenb && !o_otp_vddqsw) v_pg++;
            if (o_otp_vddqsw && !vq_d) vq_rise++;
            if (!o_otp_csb) csb_low++;
            if (!o_otp_csb && first_csb_t < 0) first_csb_t = $time;
            vq_d  = o_otp_vddqsw;
            stb_d = o_otp_strobe;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge sys_clk);
            #1;
        end
    endtask

    task automatic wait_op(input int max, output bit ok);
        int n = 0;
        while (n < max && o_otp_csb) begin
            cyc(1);
            n++;
        end
        while (n < max && !(o_otp_csb && !o_otp_vddqsw)) begin
            cyc(1);
            n++;
        end
        ok = (n < max);
    endtask

    task automatic pulse_prog();
        i_otp_prog = 1'b1;
        cyc(2);
        i_otp_prog = 1'b0;
    endtask

    task automatic test_reset();
        logic [26:0] got, exp;
        exp = {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 7'h00, 8'h00, 7'h7F};
        #1;
        got = {o_otp_vddqsw, o_otp_csb, o_otp_strobe, o_otp_load,
               o_otp_pgenb, o_otp_addr, o_xbus_din, o_xbus_addr};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL reset_outs got=%h exp=%h", got, exp);
        end
        #11 rst_n = 1'b0;
        #1;
        got = {o_otp_vddqsw, o_otp_csb, o_otp_strobe, o_otp_load,
               o_otp_pgenb, o_otp_addr, o_xbus_din, o_xbus_addr};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL reset_release got=%h exp=%h", got, exp);
        end
        #12 i_i2c_busy = 1'b0;
    endtask

    task automatic test_autoload();
        bit ok;
        logic [6:0] ea;
        wait_op(300, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL autoload_timeout got=0 exp=1");
        end
        checks++;
        if (first_csb_t <= 25 || first_csb_t > 60) begin
            failures++;
            $display("FAIL autoload_start got=%0d exp=(25,60]", first_csb_t);
        end
        checks++;
        if (w_n !== 16) begin
            failures++;
            $display("FAIL autoload_writes got=%0d exp=16", w_n);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (w_addr[i] !== 7'(i) || w_data[i] !== 8'hA5) begin
                failures++;
                $display("FAIL autoload_wr%0d got=%h/%h exp=%h/a5",
                         i, w_addr[i], w_data[i], 7'(i));
            end
            ea = {4'(i), 3'b000};
            checks++;
            if (s_addr[i] !== ea || s_w[i] !== 2 || s_pg[i] !== 1'b0) begin
                failures++;
                $display("FAIL autoload_stb%0d got=%h/w%0d exp=%h/w2",
                         i, s_addr[i], s_w[i], ea);
            end
        end
        checks++;
        if ({o_otp_csb, o_otp_load, o_otp_addr, o_xbus_addr, o_xbus_din}
            !== {1'b1, 1'b0, 7'h00, 7'h7F, 8'hA5}) begin
            failures++;
            $display("FAIL autoload_idle got=%b%b %h %h %h exp=10 00 7f a5",
                     o_otp_csb, o_otp_load, o_otp_addr, o_xbus_addr, o_xbus_din);
        end
    endtask

    task automatic test_program();
        bit ok;
        int sb, wb, vb, cb, pb, j;
        logic [2:0] bits[4];
        logic [6:0] ea;
        bits[0] = 3'd1; bits[1] = 3'd2; bits[2] = 3'd5; bits[3] = 3'd6;
        sb = s_n; wb = w_n; vb = vq_rise; cb = v_csb; pb = v_pg;
        i_run_test_mode = 1'b1;
        i_xbus_dout = 8'h66;
        cyc(1);
        pulse_prog();
        wait_op(1200, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL prog_timeout got=0 exp=1");
        end
        checks++;
        if (s_n - sb !== 64) begin
            failures++;
            $display("FAIL prog_count got=%0d exp=64", s_n - sb);
        end
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 4; k++) begin
                j = sb + i * 4 + k;
                ea = {4'(i), bits[k]};
                checks++;
                if (s_addr[j] !== ea || s_w[j] !== 4 || s_pg[j] !== 1'b1) begin
                    failures++;
                    $display("FAIL prog_stb%0d got=%h/w%0d/pg%0b exp=%h/w4/pg1",
                             j - sb, s_addr[j], s_w[j], s_pg[j], ea);
                end
            end
        end
        checks++;
        if (w_n - wb !== 0 || vq_rise - vb !== 1) begin
            failures++;
            $display("FAIL prog_side got=wr%0d/vq%0d exp=wr0/vq1",
                     w_n - wb, vq_rise - vb);
        end
        checks++;
        if (v_csb - cb !== 0 || v_pg - pb !== 0) begin
            failures++;
            $display("FAIL prog_interlock got=%0d/%0d exp=0/0",
                     v_csb - cb, v_pg - pb);
        end
    endtask

    task automatic test_no_prog();
        int sb, vb, cb;
        sb = s_n; vb = vq_rise; cb = csb_low;
        i_run_test_mode = 1'b0;
        cyc(1);
        pulse_prog();
        cyc(10);
        i_run_test_mode = 1'b1;
        cyc(20);
        checks++;
        if (s_n - sb !== 0 || vq_rise - vb !== 0 || csb_low - cb !== 0) begin
            failures++;
            $display("FAIL noprog got=stb%0d/vq%0d/csb%0d exp=0/0/0",
                     s_n - sb, vq_rise - vb, csb_low - cb);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int wb, vb, sb, j;
        logic [6:0] ea;
        wb = w_n; vb = vq_rise;
        i_otp_q = 8'h3C;
        i_xbus_dout = 8'h81;
        i_otp_read_n = 1'b0;
        i_otp_prog = 1'b1;
        cyc(1);
        i_otp_read_n = 1'b1;
        cyc(1);
        i_otp_prog = 1'b0;
        wait_op(300, ok);
        checks++;
        if (!ok || w_n - wb !== 16 || vq_rise - vb !== 0) begin
            failures++;
            $display("FAIL b2b_read_first got=ok%0b/wr%0d/vq%0d exp=1/16/0",
                     ok, w_n - wb, vq_rise - vb);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (w_addr[wb + i] !== 7'(i) || w_data[wb + i] !== 8'h3C) begin
                failures++;
                $display("FAIL b2b_wr%0d got=%h/%h exp=%h/3c",
                         i, w_addr[wb + i], w_data[wb + i], 7'(i));
            end
        end
        sb = s_n;
        wait_op(1200, ok);
        checks++;
        if (!ok || s_n - sb !== 32 || vq_rise - vb !== 1) begin
            failures++;
            $display("FAIL b2b_prog got=ok%0b/stb%0d/vq%0d exp=1/32/1",
                     ok, s_n - sb, vq_rise - vb);
        end
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 2; k++) begin
                j = sb + i * 2 + k;
                ea = {4'(i), (k == 0) ? 3'd0 : 3'd7};
                checks++;
                if (s_addr[j] !== ea || s_w[j] !== 4) begin
                    failures++;
                    $display("FAIL b2b_stb%0d got=%h/w%0d exp=%h/w4",
                             j - sb, s_addr[j], s_w[j], ea);
                end
            end
        end
    endtask

    task automatic test_abort();
        int n = 0;
        logic [3:0] got;
        i_xbus_dout = 8'h66;
        i_run_test_mode = 1'b1;
        pulse_prog();
        while (n < 200 && !(o_otp_strobe && !o_otp_load)) begin
            cyc(1);
            n++;
        end
        checks++;
        if (n >= 200) begin
            failures++;
            $display("FAIL abort_nostrobe got=%0d exp=<200", n);
        end
        i_run_test_mode = 1'b0;
        cyc(1);
        got = {o_otp_strobe, o_otp_vddqsw, o_otp_pgenb, o_otp_csb};
        checks++;
        if (got !== 4'b0111) begin
            failures++;
            $display("FAIL abort_vqoff got=%b exp=0111", got);
        end
        cyc(2);
        got = {o_otp_strobe, o_otp_vddqsw, o_otp_pgenb, o_otp_csb};
        checks++;
        if (got !== 4'b0011) begin
            failures++;
            $display("FAIL abort_idle got=%b exp=0011", got);
        end
    endtask

    task automatic test_reset_mid_strobe();
        bit ok;
        int n = 0;
        int wb, vb, cb;
        logic [25:0] got;
        i_run_test_mode = 1'b1;
        i_xbus_dout = 8'h66;
        i_otp_q = 8'h5A;
        cyc(1);
        pulse_prog();
        while (n < 200 && !(o_otp_strobe && !o_otp_load)) begin
            cyc(1);
            n++;
        end
        #2 rst_n = 1'b1;
        i_i2c_busy = 1'b1;
        #1;
        got = {o_otp_strobe, o_otp_vddqsw, o_otp_pgenb, o_otp_csb,
               o_otp_load, o_xbus_addr, o_otp_addr, o_xbus_din};
        checks++;
        if (n >= 200 || got !== {4'b0011, 1'b0, 7'h7F, 7'h00, 8'h00}) begin
            failures++;
            $display("FAIL rst_mid got=%h exp=%h n=%0d", got,
                     {4'b0011, 1'b0, 7'h7F, 7'h00, 8'h00}, n);
        end
        cyc(2);
        rst_n = 1'b0;
        wb = w_n; vb = vq_rise; cb = csb_low;
        cyc(10);
        checks++;
        if (csb_low - cb !== 0 || w_n - wb !== 0) begin
            failures++;
            $display("FAIL rst_busy_hold got=csb%0d/wr%0d exp=0/0",
                     csb_low - cb, w_n - wb);
        end
        i_i2c_busy = 1'b0;
        wait_op(300, ok);
        checks++;
        if (!ok || w_n - wb !== 16) begin
            failures++;
            $display("FAIL rst_reload got=ok%0b/wr%0d exp=1/16", ok, w_n - wb);
        end
        checks++;
        if (w_data[wb + 15] !== 8'h5A || w_addr[wb + 15] !== 7'd15) begin
            failures++;
            $display("FAIL rst_reload_data got=%h/%h exp=0f/5a",
                     w_addr[wb + 15], w_data[wb + 15]);
        end
        cyc(40);
        checks++;
        if (vq_rise - vb !== 0) begin
            failures++;
            $display("FAIL rst_no_resume got=%0d exp=0", vq_rise - vb);
        end
    endtask

    task automatic test_random_read();
        bit ok;
        int wb;
        longint t0, k;
        for (int i = 0; i < 128; i++) tbl[i] = 8'($urandom);
        wb = w_n;
        cyc(1);
        #1;
        t0 = $time;
        fork
            begin
                for (int m = 0; m < 128; m++) begin
                    i_otp_q = tbl[m];
                    #12;
                end
            end
        join_none
        i_otp_read_n = 1'b0;
        cyc(1);
        i_otp_read_n = 1'b1;
        wait_op(300, ok);
        checks++;
        if (!ok || w_n - wb !== 16) begin
            failures++;
            $display("FAIL rand_count got=ok%0b/wr%0d exp=1/16", ok, w_n - wb);
        end
        for (int i = 0; i < 16; i++) begin
            k = (w_time[wb + i] - 5 - t0) / 12;
            if (k < 0) k = 0;
            if (k > 127) k = 127;
            checks++;
            if (w_addr[wb + i] !== 7'(i) || w_data[wb + i] !== tbl[k]) begin
                failures++;
                $display("FAIL rand_wr%0d got=%h/%h exp=%h/%h",
                         i, w_addr[wb + i], w_data[wb + i], 7'(i), tbl[k]);
            end
        end
    endtask

    initial begin
        rst_n           = 1'b1;
        i_i2c_busy      = 1'b1;
        i_run_test_mode = 1'b0;
        i_otp_read_n    = 1'b1;
        i_otp_prog      = 1'b0;
        i_otp_q         = 8'hA5;
        i_xbus_dout     = 8'h00;
        test_reset();
        test_autoload();
        test_program();
        test_no_prog();
        test_back_to_back();
        test_abort();
        test_reset_mid_strobe();
        test_random_read();
        checks++;
        if (v_csb !== 0 || v_pg !== 0) begin
            failures++;
            $display("FAIL interlock_total got=%0d/%0d exp=0/0", v_csb, v_pg);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
